// File: rtl/logic_exec_stage.sv
// Registered bitwise-logic execute stage (AND/OR/XOR/NAND) with zero/parity flags.
// A main output register plus one skid register absorb writeback backpressure
// while keeping results strictly in order.
module logic_exec_stage #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zero,
  output logic             out_parity,
  output logic [CNT_W-1:0] retired_cnt
);

  localparam logic [1:0] OpAnd  = 2'b00;
  localparam logic [1:0] OpOr   = 2'b01;
  localparam logic [1:0] OpXor  = 2'b10;
  localparam logic [1:0] OpNand = 2'b11;

  // Skid entry; the main entry lives directly in the output registers.
  logic             skid_valid;
  logic [WIDTH-1:0] skid_data;
  logic             skid_zero;
  logic             skid_parity;

  logic [WIDTH-1:0] result;
  logic             result_zero;
  logic             result_parity;
  logic             accept;
  logic             xfer;

  // Ready depends only on register state, never on in_valid.
  assign in_ready = ~skid_valid;
  assign accept   = in_valid & in_ready;
  assign xfer     = out_valid & out_ready;

  // Bitwise operation and flags for the incoming operands.
  always_comb begin
    result = '0;
    case (in_op)
      OpAnd:   result = in_a & in_b;
      OpOr:    result = in_a | in_b;
      OpXor:   result = in_a ^ in_b;
      OpNand:  result = ~(in_a & in_b);
      default: result = '0;
    endcase
    result_zero   = (result == '0);
    result_parity = ^result;
  end

  // Main/skid register update; skid only fills when main stalls, and drains into main first.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_zero    <= 1'b0;
      out_parity  <= 1'b0;
      skid_valid  <= 1'b0;
      skid_data   <= '0;
      skid_zero   <= 1'b0;
      skid_parity <= 1'b0;
    end else if (!out_valid) begin
      if (accept) begin
        out_valid  <= 1'b1;
        out_data   <= result;
        out_zero   <= result_zero;
        out_parity <= result_parity;
      end
    end else if (xfer) begin
      if (skid_valid) begin
        out_data   <= skid_data;
        out_zero   <= skid_zero;
        out_parity <= skid_parity;
        skid_valid <= 1'b0;
      end else if (accept) begin
        out_data   <= result;
        out_zero   <= result_zero;
        out_parity <= result_parity;
      end else begin
        out_valid <= 1'b0;
      end
    end else if (accept) begin
      // accept here implies skid empty
      skid_valid  <= 1'b1;
      skid_data   <= result;
      skid_zero   <= result_zero;
      skid_parity <= result_parity;
    end
  end

  // Retired-result counter, wraps naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      retired_cnt <= '0;
    end else if (xfer) begin
      retired_cnt <= retired_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_logic_exec_stage.sv
// Directed, table-driven bench for logic_exec_stage.
module tb_logic_exec_stage;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic [1:0] in_op;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_zero;
  logic       out_parity;
  logic [15:0] retired_cnt;

  logic       in_ready4;
  logic       out_valid4;
  logic [7:0] out_data4;
  logic       out_zero4;
  logic       out_parity4;
  logic [3:0] retired_cnt4;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  logic_exec_stage #(.WIDTH(8), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_zero(out_zero),
    .out_parity(out_parity), .retired_cnt(retired_cnt)
  );

  // Narrow-counter copy sharing the same stimulus, used for the wrap check.
  logic_exec_stage #(.WIDTH(8), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .out_valid(out_valid4),
    .out_ready(out_ready), .out_data(out_data4), .out_zero(out_zero4),
    .out_parity(out_parity4), .retired_cnt(retired_cnt4)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [1:0] op;
    logic [7:0] d;
    logic       z;
    logic       p;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    in_op = op;
  endtask

  // Stream vectors back to back with out_ready=1, then drain.
  task automatic run_vecs(input int lo, input int hi);
    out_ready = 1'b1;
    for (int i = lo; i <= hi; i++) begin
      drive(vecs[i].a, vecs[i].b, vecs[i].op);
      step();
      check($sformatf("vec%0d valid", i), {31'd0, out_valid}, 32'd1);
      check($sformatf("vec%0d data", i), {24'd0, out_data}, {24'd0, vecs[i].d});
      check($sformatf("vec%0d zero", i), {31'd0, out_zero}, {31'd0, vecs[i].z});
      check($sformatf("vec%0d parity", i), {31'd0, out_parity}, {31'd0, vecs[i].p});
      check($sformatf("vec%0d in_ready", i), {31'd0, in_ready}, 32'd1);
    end
    in_valid = 1'b0;
    step();
    check("drain valid", {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    in_a = '0;
    in_b = '0;
    in_op = '0;
    vecs[0] = '{8'hF0, 8'h3C, 2'b00, 8'h30, 1'b0, 1'b0};
    vecs[1] = '{8'hF0, 8'h3C, 2'b01, 8'hFC, 1'b0, 1'b0};
    vecs[2] = '{8'hF0, 8'h3C, 2'b10, 8'hCC, 1'b0, 1'b0};
    vecs[3] = '{8'hF0, 8'h3C, 2'b11, 8'hCF, 1'b0, 1'b0};
    vecs[4] = '{8'hA5, 8'hA5, 2'b10, 8'h00, 1'b1, 1'b0};
    vecs[5] = '{8'h01, 8'h00, 2'b01, 8'h01, 1'b0, 1'b1};
    vecs[6] = '{8'h12, 8'h34, 2'b00, 8'h10, 1'b0, 1'b1};
    vecs[7] = '{8'h07, 8'h00, 2'b10, 8'h07, 1'b0, 1'b1};
    vecs[8] = '{8'hFF, 8'hFF, 2'b11, 8'h00, 1'b1, 1'b0};
    vecs[9] = '{8'h00, 8'h00, 2'b11, 8'hFF, 1'b0, 1'b0};

    // Reset state
    do_reset();
    check("rst out_valid", {31'd0, out_valid}, 32'd0);
    check("rst in_ready", {31'd0, in_ready}, 32'd1);
    check("rst out_data", {24'd0, out_data}, 32'd0);
    check("rst zero", {31'd0, out_zero}, 32'd0);
    check("rst parity", {31'd0, out_parity}, 32'd0);
    check("rst cnt", {16'd0, retired_cnt}, 32'd0);

    // Four ops back to back, then flag corner cases
    run_vecs(0, 3);
    check("cnt after 4", {16'd0, retired_cnt}, 32'd4);
    run_vecs(4, 9);
    check("cnt after 10", {16'd0, retired_cnt}, 32'd10);

    // Backpressure: fill M and S, hold third op upstream
    out_ready = 1'b0;
    drive(8'h11, 8'h00, 2'b01);
    step();
    check("bp M=11", {24'd0, out_data}, 32'h11);
    check("bp ready1", {31'd0, in_ready}, 32'd1);
    drive(8'h22, 8'h00, 2'b01);
    step();
    check("bp ready0", {31'd0, in_ready}, 32'd0);
    check("bp hold 11 a", {24'd0, out_data}, 32'h11);
    drive(8'h33, 8'h00, 2'b01);
    step();
    check("bp hold 11 b", {24'd0, out_data}, 32'h11);
    check("bp still full", {31'd0, in_ready}, 32'd0);
    step();
    check("bp hold 11 c", {24'd0, out_data}, 32'h11);
    check("bp valid", {31'd0, out_valid}, 32'd1);
    out_ready = 1'b1;
    step();
    check("bp out 22", {24'd0, out_data}, 32'h22);
    check("bp ready back", {31'd0, in_ready}, 32'd1);
    step();
    check("bp out 33", {24'd0, out_data}, 32'h33);
    check("bp valid 33", {31'd0, out_valid}, 32'd1);
    in_valid = 1'b0;
    step();
    check("bp drained", {31'd0, out_valid}, 32'd0);
    check("bp cnt", {16'd0, retired_cnt}, 32'd13);

    // Reset while M and S are full
    out_ready = 1'b0;
    drive(8'hAA, 8'h55, 2'b01);
    step();
    drive(8'hAA, 8'h55, 2'b10);
    step();
    check("pre-rst full", {31'd0, in_ready}, 32'd0);
    do_reset();
    check("midrst out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst in_ready", {31'd0, in_ready}, 32'd1);
    check("midrst cnt", {16'd0, retired_cnt}, 32'd0);
    out_ready = 1'b1;
    drive(8'h5A, 8'h0F, 2'b00);
    step();
    check("post-rst valid", {31'd0, out_valid}, 32'd1);
    check("post-rst data", {24'd0, out_data}, 32'h0A);
    check("post-rst parity", {31'd0, out_parity}, 32'd0);
    in_valid = 1'b0;
    step();
    check("post-rst drained", {31'd0, out_valid}, 32'd0);
    check("post-rst cnt", {16'd0, retired_cnt}, 32'd1);

    // Counter wrap on the 4-bit copy: 17 retirements
    do_reset();
    check("wrap rst cnt4", {28'd0, retired_cnt4}, 32'd0);
    out_ready = 1'b1;
    for (int k = 0; k <= 16; k++) begin
      drive(k[7:0], 8'h00, 2'b01);
      step();
      if (k == 15) begin
        check("wrap cnt4=15", {28'd0, retired_cnt4}, 32'd15);
      end
      if (k == 16) begin
        check("wrap cnt4=0", {28'd0, retired_cnt4}, 32'd0);
        check("wrap cnt16=16", {16'd0, retired_cnt}, 32'd16);
      end
    end
    in_valid = 1'b0;
    step();
    check("wrap cnt4=1", {28'd0, retired_cnt4}, 32'd1);
    check("wrap cnt16=17", {16'd0, retired_cnt}, 32'd17);
    check("wrap last data", {24'd0, out_data}, 32'h10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
